// File: rtl/svc_axi_pkg.sv
// Shared AXI encodings used by the AXI memory subordinate and its neighbours.
package svc_axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

endpackage

// File: rtl/svc_axi_mem.sv
// AXI subordinate over a flop-array memory: one write and one read burst in flight,
// every burst treated as full-width INCR, IDs echoed on B and R.
module svc_axi_mem
    import svc_axi_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 8,
    parameter int AXI_DATA_WIDTH = 16,
    parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
    parameter int AXI_ID_WIDTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_axi_awvalid,
    input  logic [AXI_ID_WIDTH-1:0]   s_axi_awid,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]                s_axi_awlen,
    input  logic [2:0]                s_axi_awsize,
    input  logic [1:0]                s_axi_awburst,
    output logic                      s_axi_awready,
    input  logic                      s_axi_wvalid,
    input  logic [AXI_DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [AXI_STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                      s_axi_wlast,
    output logic                      s_axi_wready,
    output logic                      s_axi_bvalid,
    output logic [AXI_ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]                s_axi_bresp,
    input  logic                      s_axi_bready,
    input  logic                      s_axi_arvalid,
    input  logic [AXI_ID_WIDTH-1:0]   s_axi_arid,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]                s_axi_arlen,
    input  logic [2:0]                s_axi_arsize,
    input  logic [1:0]                s_axi_arburst,
    output logic                      s_axi_arready,
    output logic                      s_axi_rvalid,
    output logic [AXI_ID_WIDTH-1:0]   s_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rlast,
    input  logic                      s_axi_rready
);

    localparam int WORD_SHIFT = $clog2(AXI_STRB_WIDTH);
    localparam int IDX_W      = AXI_ADDR_WIDTH - WORD_SHIFT;
    localparam int DEPTH      = 1 << IDX_W;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

    logic [AXI_DATA_WIDTH-1:0] mem_r [DEPTH];

    w_state_e                  w_state_r, w_next_s;
    logic                      awready_r, wready_r, bvalid_r, w_err_r;
    logic [AXI_ID_WIDTH-1:0]   w_id_r, bid_r;
    logic [1:0]                bresp_r;
    logic [IDX_W-1:0]          w_idx_r;
    logic [7:0]                w_len_r, w_cnt_r;
    logic                      aw_hs_s, w_hs_s, b_hs_s, w_last_beat_s, w_beat_err_s;

    r_state_e                  r_state_r, r_next_s;
    logic                      arready_r, rvalid_r, rlast_r;
    logic [AXI_ID_WIDTH-1:0]   rid_r;
    logic [AXI_DATA_WIDTH-1:0] rdata_r;
    logic [IDX_W-1:0]          r_idx_r, ar_idx_s, r_idx_next_s;
    logic [7:0]                r_len_r, r_cnt_r;
    logic                      ar_hs_s, r_hs_s, r_last_beat_s;

    // Size, burst type and sub-word address bits carry no meaning here.
    logic unused_s;
    assign unused_s = ^{s_axi_awsize, s_axi_awburst, s_axi_arsize, s_axi_arburst,
                        s_axi_awaddr, s_axi_araddr};

    assign aw_hs_s       = s_axi_awvalid & awready_r;
    assign w_hs_s        = s_axi_wvalid & wready_r;
    assign b_hs_s        = bvalid_r & s_axi_bready;
    assign w_last_beat_s = (w_cnt_r == w_len_r);
    assign w_beat_err_s  = (s_axi_wlast != w_last_beat_s);

    assign ar_hs_s       = s_axi_arvalid & arready_r;
    assign r_hs_s        = rvalid_r & s_axi_rready;
    assign r_last_beat_s = (r_cnt_r == r_len_r);
    assign ar_idx_s      = s_axi_araddr[AXI_ADDR_WIDTH-1:WORD_SHIFT];
    assign r_idx_next_s  = r_idx_r + IDX_W'(1);

    assign s_axi_awready = awready_r;
    assign s_axi_wready  = wready_r;
    assign s_axi_bvalid  = bvalid_r;
    assign s_axi_bid     = bid_r;
    assign s_axi_bresp   = bresp_r;
    assign s_axi_arready = arready_r;
    assign s_axi_rvalid  = rvalid_r;
    assign s_axi_rid     = rid_r;
    assign s_axi_rdata   = rdata_r;
    assign s_axi_rlast   = rlast_r;
    assign s_axi_rresp   = AXI_RESP_OKAY;

    // Write FSM next state; the beat count, not wlast, closes the burst.
    always_comb begin
        w_next_s = w_state_r;
        case (w_state_r)
            W_IDLE:  if (aw_hs_s) w_next_s = W_DATA; else w_next_s = W_IDLE;
            W_DATA:  if (w_hs_s && w_last_beat_s) w_next_s = W_RESP; else w_next_s = W_DATA;
            W_RESP:  if (b_hs_s) w_next_s = W_IDLE; else w_next_s = W_RESP;
            default: w_next_s = W_IDLE;
        endcase
    end

    // Write state, handshake flags, burst tracking and B response registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state_r <= W_IDLE;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            w_err_r   <= 1'b0;
            w_id_r    <= {AXI_ID_WIDTH{1'b0}};
            bid_r     <= {AXI_ID_WIDTH{1'b0}};
            bresp_r   <= AXI_RESP_OKAY;
            w_idx_r   <= {IDX_W{1'b0}};
            w_len_r   <= 8'd0;
            w_cnt_r   <= 8'd0;
        end else begin
            w_state_r <= w_next_s;
            awready_r <= (w_next_s == W_IDLE);
            wready_r  <= (w_next_s == W_DATA);
            bvalid_r  <= (w_next_s == W_RESP);
            if (aw_hs_s) begin
                w_id_r  <= s_axi_awid;
                w_idx_r <= s_axi_awaddr[AXI_ADDR_WIDTH-1:WORD_SHIFT];
                w_len_r <= s_axi_awlen;
                w_cnt_r <= 8'd0;
                w_err_r <= 1'b0;
            end else if (w_hs_s) begin
                w_idx_r <= w_idx_r + IDX_W'(1);
                w_cnt_r <= w_cnt_r + 8'd1;
                w_err_r <= w_err_r | w_beat_err_s;
            end
            if (w_hs_s && w_last_beat_s) begin
                bid_r   <= w_id_r;
                bresp_r <= (w_err_r | w_beat_err_s) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            end
        end
    end

    // Byte-enabled memory write; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_hs_s) begin
            for (int b = 0; b < AXI_STRB_WIDTH; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem_r[w_idx_r][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read FSM next state.
    always_comb begin
        r_next_s = r_state_r;
        case (r_state_r)
            R_IDLE:  if (ar_hs_s) r_next_s = R_DATA; else r_next_s = R_IDLE;
            R_DATA:  if (r_hs_s && r_last_beat_s) r_next_s = R_IDLE; else r_next_s = R_DATA;
            default: r_next_s = R_IDLE;
        endcase
    end

    // Read state and R channel registers; data preloads one beat ahead of the handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_r <= R_IDLE;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rlast_r   <= 1'b0;
            rid_r     <= {AXI_ID_WIDTH{1'b0}};
            rdata_r   <= {AXI_DATA_WIDTH{1'b0}};
            r_idx_r   <= {IDX_W{1'b0}};
            r_len_r   <= 8'd0;
            r_cnt_r   <= 8'd0;
        end else begin
            r_state_r <= r_next_s;
            arready_r <= (r_next_s == R_IDLE);
            rvalid_r  <= (r_next_s == R_DATA);
            if (ar_hs_s) begin
                rid_r   <= s_axi_arid;
                r_len_r <= s_axi_arlen;
                r_cnt_r <= 8'd0;
                r_idx_r <= ar_idx_s;
                rdata_r <= mem_r[ar_idx_s];
                rlast_r <= (s_axi_arlen == 8'd0);
            end else if (r_hs_s) begin
                if (r_last_beat_s) begin
                    rlast_r <= 1'b0;
                end else begin
                    r_cnt_r <= r_cnt_r + 8'd1;
                    r_idx_r <= r_idx_next_s;
                    rdata_r <= mem_r[r_idx_next_s];
                    rlast_r <= ((r_cnt_r + 8'd1) == r_len_r);
                end
            end
        end
    end

endmodule

// File: tb/tb_svc_axi_mem.sv
// Randomized bench for svc_axi_mem against a byte-array model of the memory.
module tb_svc_axi_mem;

    localparam int DEPTH = 128;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_axi_awvalid, s_axi_awready;
    logic [3:0]  s_axi_awid;
    logic [7:0]  s_axi_awaddr, s_axi_awlen;
    logic [2:0]  s_axi_awsize;
    logic [1:0]  s_axi_awburst;
    logic        s_axi_wvalid, s_axi_wlast, s_axi_wready;
    logic [15:0] s_axi_wdata;
    logic [1:0]  s_axi_wstrb;
    logic        s_axi_bvalid, s_axi_bready;
    logic [3:0]  s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_arvalid, s_axi_arready;
    logic [3:0]  s_axi_arid;
    logic [7:0]  s_axi_araddr, s_axi_arlen;
    logic [2:0]  s_axi_arsize;
    logic [1:0]  s_axi_arburst;
    logic        s_axi_rvalid, s_axi_rlast, s_axi_rready;
    logic [3:0]  s_axi_rid;
    logic [15:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;

    logic [7:0]  mem_m [2*DEPTH];
    logic [15:0] wdata_q [256];
    logic [1:0]  wstrb_q [256];
    int          n_checks = 0;
    int          n_fail = 0;

    svc_axi_mem dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr),
        .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
        .s_axi_awready(s_axi_awready),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wlast(s_axi_wlast), .s_axi_wready(s_axi_wready),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
        .s_axi_bready(s_axi_bready),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr),
        .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arready(s_axi_arready),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata),
        .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast), .s_axi_rready(s_axi_rready)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_word(input int w);
        return {mem_m[(w % DEPTH)*2 + 1], mem_m[(w % DEPTH)*2]};
    endfunction

    // wlast_mode 0: correct wlast; 1: wlast only on beat 0 (early and missing).
    task automatic axi_write(input logic [7:0] addr, input int len, input logic [3:0] id,
                             input int wlast_mode);
        int n;
        int w;
        logic err;
        s_axi_awvalid = 1'b1;
        s_axi_awaddr  = addr;
        s_axi_awlen   = 8'(len);
        s_axi_awid    = id;
        s_axi_awsize  = 3'($urandom_range(0, 7));
        s_axi_awburst = 2'($urandom_range(0, 3));
        n = 0;
        while (!s_axi_awready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            check_val("aw_timeout", 64'd1, 64'd0);
            s_axi_awvalid = 1'b0;
            return;
        end
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        check_val("awready_busy", 64'(s_axi_awready), 64'd0);
        err = 1'b0;
        for (int i = 0; i <= len; i++) begin
            check_val("wready", 64'(s_axi_wready), 64'd1);
            s_axi_wvalid = 1'b1;
            s_axi_wdata  = wdata_q[i];
            s_axi_wstrb  = wstrb_q[i];
            s_axi_wlast  = (wlast_mode == 0) ? (i == len) : (i == 0);
            if (s_axi_wlast != (i == len)) err = 1'b1;
            w = ((addr >> 1) + i) % DEPTH;
            for (int b = 0; b < 2; b++) begin
                if (wstrb_q[i][b]) mem_m[w*2 + b] = wdata_q[i][b*8 +: 8];
            end
            @(negedge clk);
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
        n = $urandom_range(0, 2);
        for (int j = 0; j <= n; j++) begin
            check_val("bvalid", 64'(s_axi_bvalid), 64'd1);
            check_val("bid", 64'(s_axi_bid), 64'(id));
            check_val("bresp", 64'(s_axi_bresp), err ? 64'd2 : 64'd0);
            if (j == n) s_axi_bready = 1'b1;
            @(negedge clk);
        end
        s_axi_bready = 1'b0;
        check_val("bvalid_clear", 64'(s_axi_bvalid), 64'd0);
        check_val("awready_back", 64'(s_axi_awready), 64'd1);
    endtask

    // rmode 0: random rready; 1: always ready; 2: toggle 1,0,1,0.
    task automatic axi_read(input logic [7:0] addr, input int len, input logic [3:0] id,
                            input int rmode);
        int n;
        int i;
        int cyc;
        logic rdy;
        s_axi_arvalid = 1'b1;
        s_axi_araddr  = addr;
        s_axi_arlen   = 8'(len);
        s_axi_arid    = id;
        s_axi_arsize  = 3'($urandom_range(0, 7));
        s_axi_arburst = 2'($urandom_range(0, 3));
        n = 0;
        while (!s_axi_arready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            check_val("ar_timeout", 64'd1, 64'd0);
            s_axi_arvalid = 1'b0;
            return;
        end
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        check_val("arready_busy", 64'(s_axi_arready), 64'd0);
        i = 0;
        cyc = 0;
        while (i <= len && cyc < 2000) begin
            check_val("rvalid", 64'(s_axi_rvalid), 64'd1);
            check_val("rdata", 64'(s_axi_rdata), 64'(model_word((addr >> 1) + i)));
            check_val("rlast", 64'(s_axi_rlast), 64'(i == len));
            check_val("rid", 64'(s_axi_rid), 64'(id));
            check_val("rresp", 64'(s_axi_rresp), 64'd0);
            if (rmode == 1) rdy = 1'b1;
            else if (rmode == 2) rdy = (cyc % 2 == 0);
            else rdy = 1'($urandom_range(0, 1));
            s_axi_rready = rdy;
            @(negedge clk);
            if (rdy) i++;
            cyc++;
        end
        s_axi_rready = 1'b0;
        if (cyc >= 2000) check_val("r_timeout", 64'd1, 64'd0);
        if (rmode == 1) check_val("r_nostall", 64'(cyc), 64'(len + 1));
        check_val("rvalid_clear", 64'(s_axi_rvalid), 64'd0);
        check_val("arready_back", 64'(s_axi_arready), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] a;
        int         l;
        rst_n = 1'b0;
        s_axi_awvalid = 1'b0; s_axi_awid = 4'd0; s_axi_awaddr = 8'd0; s_axi_awlen = 8'd0;
        s_axi_awsize = 3'd0; s_axi_awburst = 2'd0;
        s_axi_wvalid = 1'b0; s_axi_wdata = 16'd0; s_axi_wstrb = 2'd0; s_axi_wlast = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_arvalid = 1'b0; s_axi_arid = 4'd0; s_axi_araddr = 8'd0; s_axi_arlen = 8'd0;
        s_axi_arsize = 3'd0; s_axi_arburst = 2'd0; s_axi_rready = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_ready", 64'({s_axi_awready, s_axi_wready, s_axi_arready}), 64'd0);
        check_val("rst_valid", 64'({s_axi_bvalid, s_axi_rvalid, s_axi_rlast}), 64'd0);
        check_val("rst_b", 64'({s_axi_bid, s_axi_bresp}), 64'd0);
        check_val("rst_r", 64'({s_axi_rid, s_axi_rresp, s_axi_rdata}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("awready_post_rst", 64'(s_axi_awready), 64'd1);
        check_val("arready_post_rst", 64'(s_axi_arready), 64'd1);

        // Define the whole memory first so the model never has unknown words.
        for (int i = 0; i < DEPTH; i++) begin
            wdata_q[i] = 16'($urandom);
            wstrb_q[i] = 2'b11;
        end
        axi_write(8'h00, DEPTH - 1, 4'd1, 0);

        wdata_q[0] = 16'hA5A5; wstrb_q[0] = 2'b11;
        axi_write(8'h04, 0, 4'd3, 0);
        axi_read(8'h04, 0, 4'd3, 0);
        check_val("word2_a5a5", 64'(model_word(2)), 64'hA5A5);

        for (int i = 0; i < 4; i++) begin
            wdata_q[i] = 16'(i + 1);
            wstrb_q[i] = 2'b11;
        end
        axi_write(8'h10, 3, 4'd5, 0);
        axi_read(8'h10, 3, 4'd6, 2);

        wdata_q[0] = 16'hFFFF; wstrb_q[0] = 2'b11;
        axi_write(8'h20, 0, 4'd7, 0);
        wdata_q[0] = 16'h1234; wstrb_q[0] = 2'b01;
        axi_write(8'h20, 0, 4'd7, 0);
        check_val("partial_model", 64'(model_word(16)), 64'hFF34);
        axi_read(8'h20, 0, 4'd8, 1);

        wdata_q[0] = 16'h1111; wdata_q[1] = 16'h2222;
        wstrb_q[0] = 2'b11;    wstrb_q[1] = 2'b11;
        axi_write(8'hFE, 1, 4'd9, 0);
        check_val("wrap_model", 64'(model_word(0)), 64'h2222);
        axi_read(8'h00, 0, 4'd9, 1);
        axi_read(8'hFE, 1, 4'd10, 0);

        for (int i = 0; i < 3; i++) begin
            wdata_q[i] = 16'($urandom);
            wstrb_q[i] = 2'b11;
        end
        axi_write(8'h30, 2, 4'd11, 1);
        axi_read(8'h30, 2, 4'd11, 1);

        for (int i = 0; i < 4; i++) begin
            wdata_q[i] = 16'($urandom);
            wstrb_q[i] = 2'b11;
        end
        fork
            axi_write(8'h40, 3, 4'd12, 0);
            axi_read(8'h80, 3, 4'd13, 1);
        join
        axi_read(8'h40, 3, 4'd12, 1);

        for (int k = 0; k < 12; k++) begin
            a = 8'($urandom);
            l = $urandom_range(0, 7);
            for (int i = 0; i <= l; i++) begin
                wdata_q[i] = 16'($urandom);
                wstrb_q[i] = 2'($urandom);
            end
            axi_write(a, l, 4'($urandom), ($urandom_range(0, 3) == 0) ? 1 : 0);
            axi_read(a, l, 4'($urandom), $urandom_range(0, 2));
            axi_read(8'($urandom), $urandom_range(0, 5), 4'($urandom), 0);
        end

        // Reset in the middle of a read burst.
        s_axi_arvalid = 1'b1; s_axi_araddr = 8'h50; s_axi_arlen = 8'd5; s_axi_arid = 4'd4;
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b1;
        @(negedge clk);
        check_val("midrd_rvalid", 64'(s_axi_rvalid), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        s_axi_rready = 1'b0;
        check_val("midrd_rst_rvalid", 64'(s_axi_rvalid), 64'd0);
        check_val("midrd_rst_arready", 64'(s_axi_arready), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("midrd_arready", 64'(s_axi_arready), 64'd1);
        check_val("midrd_rvalid_off", 64'(s_axi_rvalid), 64'd0);
        axi_read(8'h50, 5, 4'd4, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
